// File: rtl/cache_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_arbiter_pkg
// Purpose : shared types and sizes for the L1I/L1D -> L2 cache arbiter.
// Contents: arb_state_t (arbiter FSM states), src_t (request source),
//           ADDR_W / LINE_W / OFFSET_W sizes, lineAddr() helper that
//           clears the byte-offset bits of an address.
// Optional: CACHE_ARBITER_ROUND_ROBIN_EN (consumed by cache_arbiter_grant).
// ---------------------------------------------------------------------------
package cache_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  // L2 only ever sees whole-line addresses.
  function automatic logic [ADDR_W-1:0] lineAddr(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cache_arbiter_grant.sv
// ---------------------------------------------------------------------------
// cache_arbiter_grant
// Purpose : picks which L1 source wins the next L2 transaction.
// Ports   : reqI_i    - L1I has a pending read
//           reqD_i    - L1D has a pending read and/or write
//           valid_o   - at least one source is pending
//           winner_o  - selected source (meaningful only when valid_o)
//           clk_i, rst_ni, grantEn_i - only present with
//           CACHE_ARBITER_ROUND_ROBIN_EN; grantEn_i marks the cycle in
//           which the arbiter actually takes the grant.
// Macro   : CACHE_ARBITER_ROUND_ROBIN_EN - alternate between sources when
//           both are pending; otherwise L1D always beats L1I.
// ---------------------------------------------------------------------------
module cache_arbiter_grant
  import cache_arbiter_pkg::*;
(
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  input  logic clk_i,
  input  logic rst_ni,
  input  logic grantEn_i,
`endif
  input  logic reqI_i,
  input  logic reqD_i,
  output logic valid_o,
  output src_t winner_o
);

  assign valid_o = reqI_i | reqD_i;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN

  src_t lastGrant_q, lastGrant_d;

  // On a tie the source that did not win last time goes first; a lone
  // requester always wins.
  always_comb begin
    winner_o = SRC_D;
    if (reqI_i && reqD_i) begin
      winner_o = (lastGrant_q == SRC_I) ? SRC_D : SRC_I;
    end else if (reqI_i) begin
      winner_o = SRC_I;
    end
  end

  // History only moves when a grant is really taken, not on every cycle
  // in which requests happen to be visible.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (grantEn_i && valid_o) begin
      lastGrant_d = winner_o;
    end
  end

  // Starting from "I" means the first tie goes to L1D.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastGrant_q <= SRC_I;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

`else

  // Fixed priority: L1D wins whenever it is pending.
  always_comb begin
    winner_o = SRC_D;
    if (reqI_i && !reqD_i) begin
      winner_o = SRC_I;
    end
  end

`endif

endmodule

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Purpose : serialises L1I line reads and L1D line reads/writebacks onto a
//           single L2 port, one outstanding L2 transaction at a time, and
//           returns the line with a one-cycle resp pulse.
// Ports   : clk, rst_n (async, active low)
//           l1i_arbi_*  - L1I request (address, read) / response (rdata, resp)
//           l1d_arbi_*  - L1D request (address, read, write, wdata) /
//                         response (rdata, resp)
//           arbi_l2_*   - registered L2 request (address, read, write, wdata)
//           l2_arbi_*   - L2 response (rdata, resp)
// Macro   : CACHE_ARBITER_ROUND_ROBIN_EN - round-robin tie break between
//           L1I and L1D instead of fixed L1D priority.
// ---------------------------------------------------------------------------
module cache_arbiter
  import cache_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] l1i_arbi_address,
  input  logic              l1i_arbi_read,
  output logic [LINE_W-1:0] l1i_arbi_rdata,
  output logic              l1i_arbi_resp,
  input  logic [ADDR_W-1:0] l1d_arbi_address,
  input  logic              l1d_arbi_read,
  input  logic              l1d_arbi_write,
  input  logic [LINE_W-1:0] l1d_arbi_wdata,
  output logic [LINE_W-1:0] l1d_arbi_rdata,
  output logic              l1d_arbi_resp,
  output logic [ADDR_W-1:0] arbi_l2_address,
  output logic              arbi_l2_read,
  output logic              arbi_l2_write,
  output logic [LINE_W-1:0] arbi_l2_wdata,
  input  logic [LINE_W-1:0] l2_arbi_rdata,
  input  logic              l2_arbi_resp
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] l2Addr_q, l2Addr_d;
  logic              l2Read_q, l2Read_d;
  logic              l2Write_q, l2Write_d;
  logic [LINE_W-1:0] l2Wdata_q, l2Wdata_d;
  logic              l1iResp_q, l1iResp_d;
  logic              l1dResp_q, l1dResp_d;
  logic [LINE_W-1:0] l1iRdata_q, l1iRdata_d;
  logic [LINE_W-1:0] l1dRdata_q, l1dRdata_d;

  logic grantValid;
  src_t grantSrc;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  logic grantEn;
  assign grantEn = (state_q == IDLE);
`endif

  cache_arbiter_grant u_grant (
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .grantEn_i (grantEn),
`endif
    .reqI_i    (l1i_arbi_read),
    .reqD_i    (l1d_arbi_read | l1d_arbi_write),
    .valid_o   (grantValid),
    .winner_o  (grantSrc)
  );

  // FSM next state plus the L2 request / L1 response datapath.
  // The L2 request is captured at grant and held untouched until L2
  // answers, so L1 inputs moving mid-transaction cannot leak through.
  // A pending L1D write beats a pending L1D read; the read simply stays
  // pending and is picked up on a later arbitration.
  // DONE grants nothing, giving the requester one cycle to drop its
  // request so it is not serviced a second time.
  always_comb begin
    state_d    = state_q;
    l2Addr_d   = l2Addr_q;
    l2Read_d   = l2Read_q;
    l2Write_d  = l2Write_q;
    l2Wdata_d  = l2Wdata_q;
    l1iResp_d  = 1'b0;
    l1dResp_d  = 1'b0;
    l1iRdata_d = l1iRdata_q;
    l1dRdata_d = l1dRdata_q;

    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          if (grantSrc == SRC_D) begin
            state_d   = SERVE_D;
            l2Addr_d  = lineAddr(l1d_arbi_address);
            l2Write_d = l1d_arbi_write;
            l2Read_d  = ~l1d_arbi_write;
            l2Wdata_d = l1d_arbi_wdata;
          end else begin
            state_d   = SERVE_I;
            l2Addr_d  = lineAddr(l1i_arbi_address);
            l2Write_d = 1'b0;
            l2Read_d  = 1'b1;
            l2Wdata_d = '0;
          end
        end
      end

      SERVE_I: begin
        if (l2_arbi_resp) begin
          state_d    = DONE;
          l2Addr_d   = '0;
          l2Read_d   = 1'b0;
          l2Write_d  = 1'b0;
          l2Wdata_d  = '0;
          l1iResp_d  = 1'b1;
          l1iRdata_d = l2_arbi_rdata;
        end
      end

      SERVE_D: begin
        if (l2_arbi_resp) begin
          state_d   = DONE;
          l2Addr_d  = '0;
          l2Read_d  = 1'b0;
          l2Write_d = 1'b0;
          l2Wdata_d = '0;
          l1dResp_d = 1'b1;
          if (l2Read_q) begin
            l1dRdata_d = l2_arbi_rdata;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset drops any in-flight L2 request on the floor; no L1 resp follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      l2Addr_q   <= '0;
      l2Read_q   <= 1'b0;
      l2Write_q  <= 1'b0;
      l2Wdata_q  <= '0;
      l1iResp_q  <= 1'b0;
      l1dResp_q  <= 1'b0;
      l1iRdata_q <= '0;
      l1dRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      l2Addr_q   <= l2Addr_d;
      l2Read_q   <= l2Read_d;
      l2Write_q  <= l2Write_d;
      l2Wdata_q  <= l2Wdata_d;
      l1iResp_q  <= l1iResp_d;
      l1dResp_q  <= l1dResp_d;
      l1iRdata_q <= l1iRdata_d;
      l1dRdata_q <= l1dRdata_d;
    end
  end

  assign arbi_l2_address = l2Addr_q;
  assign arbi_l2_read    = l2Read_q;
  assign arbi_l2_write   = l2Write_q;
  assign arbi_l2_wdata   = l2Wdata_q;
  assign l1i_arbi_resp   = l1iResp_q;
  assign l1i_arbi_rdata  = l1iRdata_q;
  assign l1d_arbi_resp   = l1dResp_q;
  assign l1d_arbi_rdata  = l1dRdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Purpose : self-checking bench for cache_arbiter. A transaction-level model
//           (busy / one-cycle gap / captured request) predicts every output
//           each cycle; directed scenarios add literal expectations.
// Macro   : CACHE_ARBITER_ROUND_ROBIN_EN - model switches to round-robin
//           tie break when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [ADDR_W-1:0] l1i_arbi_address = '0;
  logic              l1i_arbi_read = 1'b0;
  logic [LINE_W-1:0] l1i_arbi_rdata;
  logic              l1i_arbi_resp;
  logic [ADDR_W-1:0] l1d_arbi_address = '0;
  logic              l1d_arbi_read = 1'b0;
  logic              l1d_arbi_write = 1'b0;
  logic [LINE_W-1:0] l1d_arbi_wdata = '0;
  logic [LINE_W-1:0] l1d_arbi_rdata;
  logic              l1d_arbi_resp;
  logic [ADDR_W-1:0] arbi_l2_address;
  logic              arbi_l2_read;
  logic              arbi_l2_write;
  logic [LINE_W-1:0] arbi_l2_wdata;
  logic [LINE_W-1:0] l2_arbi_rdata = '0;
  logic              l2_arbi_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .l1i_arbi_address (l1i_arbi_address),
    .l1i_arbi_read    (l1i_arbi_read),
    .l1i_arbi_rdata   (l1i_arbi_rdata),
    .l1i_arbi_resp    (l1i_arbi_resp),
    .l1d_arbi_address (l1d_arbi_address),
    .l1d_arbi_read    (l1d_arbi_read),
    .l1d_arbi_write   (l1d_arbi_write),
    .l1d_arbi_wdata   (l1d_arbi_wdata),
    .l1d_arbi_rdata   (l1d_arbi_rdata),
    .l1d_arbi_resp    (l1d_arbi_resp),
    .arbi_l2_address  (arbi_l2_address),
    .arbi_l2_read     (arbi_l2_read),
    .arbi_l2_write    (arbi_l2_write),
    .arbi_l2_wdata    (arbi_l2_wdata),
    .l2_arbi_rdata    (l2_arbi_rdata),
    .l2_arbi_resp     (l2_arbi_resp)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model state: one L2 transaction in flight at most,
  // followed by a one-cycle gap in which nothing is granted.
  bit              mBusy, mGap, mSrcD, mWrite;
  logic [31:0]     mAddr;
  logic [255:0]    mWdata;
  bit              mRespI, mRespD;
  logic [255:0]    mRdataI, mRdataD;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  bit              mLastD;
`endif

  // Observed L2 transactions in directed scenarios.
  logic [31:0]  gAddr[$];
  bit           gWrite[$];
  logic [255:0] gWdata[$];

  function automatic logic [255:0] randLine();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void modelReset();
    mBusy = 0; mGap = 0; mSrcD = 0; mWrite = 0;
    mAddr = '0; mWdata = '0;
    mRespI = 0; mRespD = 0;
    mRdataI = '0; mRdataD = '0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    mLastD = 0;
`endif
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void modelStep();
    bit pendI, pendD, pickD;
    pendI = l1i_arbi_read;
    pendD = l1d_arbi_read | l1d_arbi_write;
    mRespI = 0;
    mRespD = 0;
    if (mBusy) begin
      if (l2_arbi_resp) begin
        mBusy = 0;
        mGap  = 1;
        if (mSrcD) begin
          mRespD = 1;
          if (!mWrite) mRdataD = l2_arbi_rdata;
        end else begin
          mRespI  = 1;
          mRdataI = l2_arbi_rdata;
        end
      end
    end else if (mGap) begin
      mGap = 0;
    end else if (pendI || pendD) begin
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      pickD  = pendD && (!pendI || !mLastD);
      mLastD = pickD;
`else
      pickD = pendD;
`endif
      mBusy = 1;
      mSrcD = pickD;
      if (pickD) begin
        mWrite = l1d_arbi_write;
        mAddr  = l1d_arbi_address & ~32'h1F;
        mWdata = l1d_arbi_wdata;
      end else begin
        mWrite = 0;
        mAddr  = l1i_arbi_address & ~32'h1F;
        mWdata = '0;
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("l2_address", 256'(arbi_l2_address), 256'(mBusy ? mAddr : 32'h0));
    cmp("l2_read",    256'(arbi_l2_read),     256'(mBusy && !mWrite));
    cmp("l2_write",   256'(arbi_l2_write),    256'(mBusy && mWrite));
    cmp("l2_wdata",   arbi_l2_wdata,          mBusy ? mWdata : 256'h0);
    cmp("l1i_resp",   256'(l1i_arbi_resp),    256'(mRespI));
    cmp("l1d_resp",   256'(l1d_arbi_resp),    256'(mRespD));
    cmp("l1i_rdata",  l1i_arbi_rdata,         mRdataI);
    cmp("l1d_rdata",  l1d_arbi_rdata,         mRdataD);
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_l2_address"}, 256'(arbi_l2_address), 256'h0);
    cmp({tag, "_l2_read"},    256'(arbi_l2_read),     256'h0);
    cmp({tag, "_l2_write"},   256'(arbi_l2_write),    256'h0);
    cmp({tag, "_l2_wdata"},   arbi_l2_wdata,          256'h0);
    cmp({tag, "_l1i_resp"},   256'(l1i_arbi_resp),    256'h0);
    cmp({tag, "_l1d_resp"},   256'(l1d_arbi_resp),    256'h0);
    cmp({tag, "_l1i_rdata"},  l1i_arbi_rdata,         256'h0);
    cmp({tag, "_l1d_rdata"},  l1d_arbi_rdata,         256'h0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  // Random L1 requesters and L2 responder, reacting to the model's view.
  task automatic applyStimulus();
    if (l1i_arbi_read) begin
      if (mRespI) begin
        if ($urandom_range(3) != 0) l1i_arbi_read = 0;
        else l1i_arbi_address = $urandom;
      end else if (!(mBusy && !mSrcD) && $urandom_range(19) == 0) begin
        l1i_arbi_read = 0;
      end else if ($urandom_range(7) == 0) begin
        l1i_arbi_address = $urandom;
      end
    end else if ($urandom_range(2) == 0) begin
      l1i_arbi_read    = 1;
      l1i_arbi_address = $urandom;
    end

    if (l1d_arbi_read || l1d_arbi_write) begin
      if (mRespD) begin
        if (l1d_arbi_write) l1d_arbi_write = 0;
        else l1d_arbi_read = 0;
      end else if (!(mBusy && mSrcD) && $urandom_range(19) == 0) begin
        l1d_arbi_read  = 0;
        l1d_arbi_write = 0;
      end else if ($urandom_range(7) == 0) begin
        l1d_arbi_address = $urandom;
        l1d_arbi_wdata   = randLine();
      end
    end else if ($urandom_range(2) == 0) begin
      case ($urandom_range(2))
        0: l1d_arbi_read = 1;
        1: l1d_arbi_write = 1;
        default: begin l1d_arbi_read = 1; l1d_arbi_write = 1; end
      endcase
      l1d_arbi_address = $urandom;
      l1d_arbi_wdata   = randLine();
    end

    if (mBusy) l2_arbi_resp = ($urandom_range(2) == 0);
    else l2_arbi_resp = ($urandom_range(7) == 0);
    l2_arbi_rdata = randLine();
  endtask

  // Directed driver: L2 answers one cycle after each request appears; L1
  // drops its request on resp (optionally one cycle late for L1I).
  task automatic serviceCycles(input int n, input bit holdExtra);
    bit prevActive, active, dropI;
    prevActive = 0;
    dropI = 0;
    for (int k = 0; k < n; k++) begin
      if (dropI) begin l1i_arbi_read = 0; dropI = 0; end
      if (l1i_arbi_resp) begin
        if (holdExtra) dropI = 1;
        else l1i_arbi_read = 0;
      end
      if (l1d_arbi_resp) begin
        if (l1d_arbi_write) l1d_arbi_write = 0;
        else l1d_arbi_read = 0;
      end
      active = arbi_l2_read | arbi_l2_write;
      if (active && !prevActive) begin
        gAddr.push_back(arbi_l2_address);
        gWrite.push_back(arbi_l2_write);
        gWdata.push_back(arbi_l2_wdata);
      end
      prevActive    = active;
      l2_arbi_resp  = active;
      l2_arbi_rdata = randLine();
      step();
    end
    l2_arbi_resp = 0;
  endtask

  task automatic clearLog();
    gAddr.delete();
    gWrite.delete();
    gWdata.delete();
  endtask

  initial begin
    int readCycles, respCount, sz;
    logic [31:0] gotA;

    modelReset();
    #2 rst_n = 0;
    @(negedge clk);
    checkAllZero("reset");
    checkOutput();
    @(negedge clk);
    rst_n = 1;
    step();

    // L1I read with L2 answering after 4 cycles.
    l1i_arbi_read    = 1;
    l1i_arbi_address = 32'h0000_1234;
    step();
    readCycles = 0;
    respCount  = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) cmp("t1_l2_address", 256'(arbi_l2_address), 256'h1220);
      if (arbi_l2_read) readCycles++;
      if (l1i_arbi_resp) begin respCount++; l1i_arbi_read = 0; end
      l2_arbi_resp  = arbi_l2_read && (readCycles == 4);
      l2_arbi_rdata = {32{8'hAB}};
      step();
    end
    l2_arbi_resp = 0;
    cmp("t1_read_cycles", 256'(readCycles), 256'd4);
    cmp("t1_resp_count",  256'(respCount),  256'd1);
    cmp("t1_rdata",       l1i_arbi_rdata,   {32{8'hAB}});

    // Simultaneous L1I and L1D reads, four rounds.
    clearLog();
    for (int rep = 0; rep < 4; rep++) begin
      l1i_arbi_read = 1; l1i_arbi_address = 32'h0000_0100;
      l1d_arbi_read = 1; l1d_arbi_address = 32'h0000_0200;
      serviceCycles(10, 0);
    end
    sz = gAddr.size();
    cmp("t2_grant_count", 256'(sz), 256'd8);
    for (int j = 0; j < 8; j++) begin
      gotA = (j < sz) ? gAddr[j] : 32'hDEAD_BEEF;
      cmp($sformatf("t2_grant%0d", j), 256'(gotA), (j % 2 == 0) ? 256'h200 : 256'h100);
    end

    // L1D read + write together: writeback first, then read of the line.
    clearLog();
    l1d_arbi_read    = 1;
    l1d_arbi_write   = 1;
    l1d_arbi_address = 32'h8000_0040;
    l1d_arbi_wdata   = {32{8'h55}};
    serviceCycles(12, 0);
    sz = gAddr.size();
    cmp("t3_count", 256'(sz), 256'd2);
    if (sz >= 2) begin
      cmp("t3_first_write",  256'(gWrite[0]), 256'd1);
      cmp("t3_first_addr",   256'(gAddr[0]),  256'h8000_0040);
      cmp("t3_first_wdata",  gWdata[0],       {32{8'h55}});
      cmp("t3_second_write", 256'(gWrite[1]), 256'd0);
      cmp("t3_second_addr",  256'(gAddr[1]),  256'h8000_0040);
    end

    // Requester holds one cycle past resp: still only one transaction.
    clearLog();
    l1i_arbi_read    = 1;
    l1i_arbi_address = 32'h0000_0C00;
    serviceCycles(10, 1);
    cmp("t4_count", 256'(gAddr.size()), 256'd1);

    // Reset while serving L1I with the L2 resp arriving.
    l1i_arbi_read    = 1;
    l1i_arbi_address = 32'h0000_0040;
    step();
    cmp("t5_serving", 256'(arbi_l2_read), 256'd1);
    l2_arbi_resp  = 1;
    l2_arbi_rdata = randLine();
    rst_n = 0;
    modelReset();
    #1;
    checkAllZero("t5_reset");
    step();
    cmp("t5_no_l1i_resp", 256'(l1i_arbi_resp), 256'd0);
    l1i_arbi_read = 0;
    l2_arbi_resp  = 0;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("t5_idle_after", 256'(arbi_l2_read), 256'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      applyStimulus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
